// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer.
// Optional feature macro: ALU_OPCHK_EN (opcode legality checking).
package alu_pkg;

    localparam int OPCODE_W = 4;
    localparam logic [OPCODE_W-1:0] OPC_MIN = 4'd1;
    localparam logic [OPCODE_W-1:0] OPC_MAX = 4'd9;

    // Default response field widths, matching the issuer's default parameters
    localparam int RSP_WIDTH = 32;
    localparam int RSP_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        CAPT = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic [RSP_WIDTH-1:0] result;
        logic [RSP_TAG_W-1:0] tag;
        logic                 err;
    } rsp_t;

    // True when the opcode is one the ALU implements
    function automatic logic opcode_legal(input logic [OPCODE_W-1:0] opc);
        return (opc >= OPC_MIN) && (opc <= OPC_MAX);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-side and response signals of the ALU command issuer.
// The slave modport is the issuer; the master modport is the surrounding system.
interface alu_cmd_issuer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [WIDTH-1:0]    cmd_op1;
    logic [WIDTH-1:0]    cmd_op2;
    logic [OPCODE_W-1:0] cmd_opcode;
    logic [TAG_W-1:0]    cmd_tag;

    logic [WIDTH-1:0]    alu_operand1;
    logic [WIDTH-1:0]    alu_operand2;
    logic [OPCODE_W-1:0] alu_opcode;
    logic [WIDTH-1:0]    alu_result;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_result;
    logic [TAG_W-1:0]    rsp_tag;
    logic                rsp_err;

    logic                busy;

    modport slave (
        input  cmd_valid, cmd_op1, cmd_op2, cmd_opcode, cmd_tag,
        input  alu_result,
        input  rsp_ready,
        output cmd_ready,
        output alu_operand1, alu_operand2, alu_opcode,
        output rsp_valid, rsp_result, rsp_tag, rsp_err,
        output busy
    );

    modport master (
        output cmd_valid, cmd_op1, cmd_op2, cmd_opcode, cmd_tag,
        output alu_result,
        output rsp_ready,
        input  cmd_ready,
        input  alu_operand1, alu_operand2, alu_opcode,
        input  rsp_valid, rsp_result, rsp_tag, rsp_err,
        input  busy
    );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module alu_rsp_fifo #(
    parameter int DATA_W = 37,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointer update; reset discards every stored entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage array, written only on an accepted write
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequential front end for a combinational ALU: accepts a command, holds it
// on the ALU inputs for SETTLE cycles, samples the result and returns it with
// its tag through a response FIFO.
// Optional feature macro: ALU_OPCHK_EN -- illegal opcodes (0, 10..15) bypass
// the ALU and return {result=0, err=1}.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int TAG_W      = 4,
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_cmd_issuer_if.slave bus
);

    localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE - 1);

`ifdef ALU_OPCHK_EN
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;
`else
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
    } entry_t;
`endif

    issuer_state_t       state_q;
    issuer_state_t       state_d;
    logic [3:0]          settle_q;
    logic [3:0]          settle_d;
    logic [WIDTH-1:0]    op1_q;
    logic [WIDTH-1:0]    op2_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [TAG_W-1:0]    tag_q;
`ifdef ALU_OPCHK_EN
    logic                err_q;
`endif

    logic                accept;
    logic                load_ops;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    entry_t              wr_entry;
    entry_t              rd_entry;

    // A command can only be taken while idle and while the FIFO can still
    // hold its response; there is no separate in-flight slot.
    assign bus.cmd_ready = rst_n && (state_q == IDLE) && (fifo_count < DEPTH_CNT);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // State and settle-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic: IDLE -> HOLD (settle countdown) -> CAPT -> IDLE
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        load_ops = 1'b0;
        fifo_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_OPCHK_EN
                    if (opcode_legal(bus.cmd_opcode)) begin
                        load_ops = 1'b1;
                        settle_d = SETTLE_INIT;
                        state_d  = HOLD;
                    end else begin
                        state_d  = CAPT;
                    end
`else
                    load_ops = 1'b1;
                    settle_d = SETTLE_INIT;
                    state_d  = HOLD;
`endif
                end
            end
            HOLD: begin
                if (settle_q == 4'd0) begin
                    state_d = CAPT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            CAPT: begin
                // Never full here: a slot was reserved when the command was taken
                fifo_wr = !fifo_full;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU operand registers; they keep the last legal command when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q    <= '0;
            op2_q    <= '0;
            opcode_q <= '0;
        end else if (load_ops) begin
            op1_q    <= bus.cmd_op1;
            op2_q    <= bus.cmd_op2;
            opcode_q <= bus.cmd_opcode;
        end
    end

    // Tag (and rejection flag) of the command currently being processed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
`ifdef ALU_OPCHK_EN
            err_q <= 1'b0;
`endif
        end else if (accept) begin
            tag_q <= bus.cmd_tag;
`ifdef ALU_OPCHK_EN
            err_q <= !opcode_legal(bus.cmd_opcode);
`endif
        end
    end

    // Response entry assembled from the live ALU result in CAPT
    always_comb begin
        wr_entry.result = bus.alu_result;
        wr_entry.tag    = tag_q;
`ifdef ALU_OPCHK_EN
        wr_entry.err    = err_q;
        if (err_q) wr_entry.result = '0;
`endif
    end

    assign fifo_rd = bus.rsp_ready && !fifo_empty;

    alu_rsp_fifo #(
        .DATA_W ($bits(entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (fifo_wr),
        .din   (wr_entry),
        .rd_en (fifo_rd),
        .dout  (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.alu_operand1 = op1_q;
    assign bus.alu_operand2 = op2_q;
    assign bus.alu_opcode   = opcode_q;

    // Response fields read as zero whenever nothing is queued
    assign bus.rsp_valid  = !fifo_empty;
    assign bus.rsp_result = fifo_empty ? '0 : rd_entry.result;
    assign bus.rsp_tag    = fifo_empty ? '0 : rd_entry.tag;
`ifdef ALU_OPCHK_EN
    assign bus.rsp_err    = !fifo_empty && rd_entry.err;
`else
    assign bus.rsp_err    = 1'b0;
`endif

    assign bus.busy = (state_q != IDLE) || !fifo_empty;

endmodule
